// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   RESET_PC_DEF / NOP_INSTR_DEF : default parameter values for fetch_stage
//   fetch_state_t                : fetch controller state encoding
//   RS_* / RT_*                  : register-field positions in an instruction word
//   align_word()                 : clears the low two address bits
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc+4, instr} plus a valid bit.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture data_in, mark valid
//   flush        : clear to {0, NOP_INSTR}, invalid (wins over load)
//   neither      : hold
//   data_in/out  : {pc[31:0], instr[31:0]}
//   valid_out    : register holds a real instruction
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        valid_out
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data_out  <= {32'h0000_0000, NOP_INSTR};
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= data_in;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack instruction-memory
// handshake and loads the IF/ID register.
//   clk, rst                      : clock, synchronous active-high reset
//   ctrlStall                     : hold PC and IF/ID (load-use hazard)
//   redirect_valid, redirect_pc   : taken branch/jump, flush and refetch
//   imem_req/addr/ack/rdata       : instruction memory handshake
//   pc_IF_ID, instr_IF_ID, valid_IF_ID : IF/ID contents
//   rs_IF_ID, rt_IF_ID            : register fields of instr_IF_ID
//
// state | meaning
// FETCH | request at pc; consume ack into IF/ID (or skid if stalled)
// HOLD  | acked word parked in skid buffer while stalled; no request
// DROP  | old request still outstanding after redirect; discard its data
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrlStall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF_ID,
  output logic [31:0] instr_IF_ID,
  output logic        valid_IF_ID,
  output logic [4:0]  rs_IF_ID,
  output logic [4:0]  rt_IF_ID
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  drop_addr;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;

  logic         if_load;
  logic         if_flush;
  logic [63:0]  if_din;
  logic [63:0]  if_dout;

  assign pc_plus4  = pc + 32'd4;
  // A request is outstanding in FETCH and DROP; reset abandons it at once.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_comb begin
    if_load  = 1'b0;
    if_flush = 1'b0;
    if_din   = {pc_plus4, imem_rdata};
    if (redirect_valid) begin
      if_flush = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (!ctrlStall) begin
            if (imem_ack) if_load  = 1'b1;
            else          if_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!ctrlStall) begin
            if_load = 1'b1;
            if_din  = {skid_pc, skid_instr};
          end
        end
        DROP: begin
          if (!ctrlStall) if_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop_addr  <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
      skid_instr <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc         <= align_word(redirect_pc);
      skid_pc    <= 32'h0000_0000;
      skid_instr <= 32'h0000_0000;
      case (state)
        FETCH: begin
          if (!imem_ack) begin
            // Memory still owes us the old word; keep asking for it so the
            // handshake stays stable, then throw it away.
            drop_addr <= pc;
            state     <= DROP;
          end
        end
        HOLD:    state <= FETCH;
        DROP:    state <= DROP;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            if (ctrlStall) begin
              skid_pc    <= pc_plus4;
              skid_instr <= imem_rdata;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!ctrlStall) begin
            skid_pc    <= 32'h0000_0000;
            skid_instr <= 32'h0000_0000;
            state      <= FETCH;
          end
        end
        DROP: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (if_load),
    .flush     (if_flush),
    .data_in   (if_din),
    .data_out  (if_dout),
    .valid_out (valid_IF_ID)
  );

  assign pc_IF_ID    = if_dout[63:32];
  assign instr_IF_ID = if_dout[31:0];
  assign rs_IF_ID    = instr_IF_ID[RS_MSB:RS_LSB];
  assign rt_IF_ID    = instr_IF_ID[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        ctrlStall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF_ID;
  logic [31:0] instr_IF_ID;
  logic        valid_IF_ID;
  logic [4:0]  rs_IF_ID;
  logic [4:0]  rt_IF_ID;

  logic        ovr_en;
  logic [31:0] ovr_data;

  int n_vec;
  int n_err;

  // Default memory returns its own address as the instruction word.
  assign imem_rdata = ovr_en ? ovr_data : imem_addr;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ctrlStall      (ctrlStall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_IF_ID       (pc_IF_ID),
    .instr_IF_ID    (instr_IF_ID),
    .valid_IF_ID    (valid_IF_ID),
    .rs_IF_ID       (rs_IF_ID),
    .rt_IF_ID       (rt_IF_ID)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_ack       = 1'b0;
    ctrlStall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ovr_en         = 1'b0;
    tick();
    tick();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_valid", {31'h0, valid_IF_ID}, 32'h0);
    chk("rst_instr", instr_IF_ID,          32'h0);
    chk("rst_pcid",  pc_IF_ID,             32'h0);
    chk("rst_addr",  imem_addr,            32'h3000);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    ovr_data = 32'h0;

    // zero-wait streaming
    do_reset();
    imem_ack = 1'b1;
    #1;
    chk("zw_req0",   {31'h0, imem_req}, 32'h1);
    chk("zw_addr0",  imem_addr, 32'h3000);
    tick();
    chk("zw_instr1", instr_IF_ID, 32'h3000);
    chk("zw_pcid1",  pc_IF_ID, 32'h3004);
    chk("zw_valid1", {31'h0, valid_IF_ID}, 32'h1);
    chk("zw_addr1",  imem_addr, 32'h3004);
    tick();
    chk("zw_instr2", instr_IF_ID, 32'h3004);
    chk("zw_pcid2",  pc_IF_ID, 32'h3008);
    chk("zw_addr2",  imem_addr, 32'h3008);
    tick();
    chk("zw_instr3", instr_IF_ID, 32'h3008);
    chk("zw_pcid3",  pc_IF_ID, 32'h300C);

    // stall for two cycles while 0x3004 is acked
    do_reset();
    imem_ack = 1'b1;
    tick();
    chk("st_instr0", instr_IF_ID, 32'h3000);
    chk("st_addr0",  imem_addr, 32'h3004);
    ctrlStall = 1'b1;
    tick();
    chk("st_instr1", instr_IF_ID, 32'h3000);
    chk("st_req1",   {31'h0, imem_req}, 32'h0);
    tick();
    chk("st_instr2", instr_IF_ID, 32'h3000);
    chk("st_req2",   {31'h0, imem_req}, 32'h0);
    chk("st_valid2", {31'h0, valid_IF_ID}, 32'h1);
    ctrlStall = 1'b0;
    tick();
    chk("st_instr3", instr_IF_ID, 32'h3004);
    chk("st_pcid3",  pc_IF_ID, 32'h3008);
    chk("st_addr3",  imem_addr, 32'h3008);
    chk("st_req3",   {31'h0, imem_req}, 32'h1);
    tick();
    chk("st_instr4", instr_IF_ID, 32'h3008);
    chk("st_pcid4",  pc_IF_ID, 32'h300C);

    // redirect together with stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    ctrlStall      = 1'b1;
    tick();
    chk("rd_valid", {31'h0, valid_IF_ID}, 32'h0);
    chk("rd_instr", instr_IF_ID, 32'h0);
    chk("rd_addr",  imem_addr, 32'h3100);
    redirect_valid = 1'b0;
    ctrlStall      = 1'b0;
    tick();
    chk("rd_instr1", instr_IF_ID, 32'h3100);
    chk("rd_valid1", {31'h0, valid_IF_ID}, 32'h1);

    // 3-cycle memory, redirect in first wait cycle of fetch 0x3008
    do_reset();
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3200;
    tick();
    chk("dr_addr1",  imem_addr, 32'h3008);
    chk("dr_req1",   {31'h0, imem_req}, 32'h1);
    chk("dr_valid1", {31'h0, valid_IF_ID}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("dr_addr2",  imem_addr, 32'h3008);
    chk("dr_valid2", {31'h0, valid_IF_ID}, 32'h0);
    imem_ack = 1'b1;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    tick();
    chk("dr_addr3",  imem_addr, 32'h3200);
    chk("dr_instr3", instr_IF_ID, 32'h0);
    chk("dr_valid3", {31'h0, valid_IF_ID}, 32'h0);
    ovr_en = 1'b0;
    tick();
    chk("dr_instr4", instr_IF_ID, 32'h3200);
    chk("dr_pcid4",  pc_IF_ID, 32'h3204);
    chk("dr_valid4", {31'h0, valid_IF_ID}, 32'h1);

    // reset mid-wait
    imem_ack = 1'b0;
    tick();
    chk("rw_bubble", {31'h0, valid_IF_ID}, 32'h0);
    rst = 1'b1;
    tick();
    chk("rw_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rw_addr",  imem_addr, 32'h3000);
    chk("rw_req1",  {31'h0, imem_req}, 32'h1);
    chk("rw_valid", {31'h0, valid_IF_ID}, 32'h0);

    // reset while in HOLD; skid content must not surface
    imem_ack = 1'b1;
    tick();
    ctrlStall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rh_valid", {31'h0, valid_IF_ID}, 32'h0);
    chk("rh_addr",  imem_addr, 32'h3000);
    rst       = 1'b0;
    ctrlStall = 1'b0;
    tick();
    chk("rh_instr", instr_IF_ID, 32'h3000);
    chk("rh_pcid",  pc_IF_ID, 32'h3004);

    // rs/rt decode of lw $t2,0($a0), held across stalls
    ovr_en   = 1'b1;
    ovr_data = 32'h8C8A_0000;
    tick();
    chk("rr_rs0",    {27'h0, rs_IF_ID}, 32'd4);
    chk("rr_rt0",    {27'h0, rt_IF_ID}, 32'd10);
    chk("rr_valid0", {31'h0, valid_IF_ID}, 32'h1);
    ctrlStall = 1'b1;
    ovr_data  = 32'h1234_5678;
    tick();
    chk("rr_rs1", {27'h0, rs_IF_ID}, 32'd4);
    chk("rr_rt1", {27'h0, rt_IF_ID}, 32'd10);
    tick();
    chk("rr_rs2",    {27'h0, rs_IF_ID}, 32'd4);
    chk("rr_rt2",    {27'h0, rt_IF_ID}, 32'd10);
    chk("rr_instr2", instr_IF_ID, 32'h8C8A_0000);
    ctrlStall = 1'b0;
    ovr_en    = 1'b0;

    // misaligned redirect near the top of memory, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    chk("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'h0, valid_IF_ID}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("wr_pcid",  pc_IF_ID, 32'h0);
    chk("wr_instr", instr_IF_ID, 32'hFFFF_FFFC);
    chk("wr_addr1", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
